// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor. Operands are captured on a valid/ready handshake,
// processed DIGIT bits per cycle LSB-first, and the result is presented with a
// valid/ready handshake. Subtraction is A + ~B + 1 (carry seeded with 1).
module serial_addsub #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk_i,
   input  logic             resetn_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sub_i,
   input  logic             abort_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o,
   output logic             ovf_o,
   output logic             busy_o,
   output logic             step_o
);

   // Guarded so a zero DIGIT reports the parameter error instead of dividing by zero.
   localparam int unsigned N  = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
   localparam int unsigned CW = $clog2(N + 1);

   if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : gen_param_err
      $error("serial_addsub: illegal WIDTH/DIGIT combination");
   end

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StShift = 2'b01,
      StDone  = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   // Output-side copies: the working registers are reused by the next operation,
   // but the presented result must hold until the next completion.
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             cmsb_q, cmsb_d;

   logic [DIGIT-1:0] a_dig, b_dig, s_dig;
   logic             c_dig;
   logic             cin_msb;
   logic             last_dig;
   logic [WIDTH-1:0] res_shift;

   // One digit of the ripple sum plus the carry into the digit's top bit.
   always_comb begin
      a_dig            = a_q[DIGIT-1:0];
      b_dig            = b_q[DIGIT-1:0];
      {c_dig, s_dig}   = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
      // Carry into a bit is recoverable as a ^ b ^ sum of that bit.
      cin_msb          = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ s_dig[DIGIT-1];
      last_dig         = (cnt_q == CW'(N - 1));
      res_shift        = (res_q >> DIGIT) | (WIDTH'(s_dig) << (WIDTH - DIGIT));
   end

   // Next-state and datapath update; abort wins over every other transition.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      cmsb_d  = cmsb_q;
      case (state_q)
         StIdle: begin
            if (in_valid_i && !abort_i) begin
               a_d     = a_i;
               b_d     = sub_i ? ~b_i : b_i;
               carry_d = sub_i;
               cnt_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            if (abort_i) begin
               state_d = StIdle;
            end else begin
               a_d     = a_q >> DIGIT;
               b_d     = b_q >> DIGIT;
               res_d   = res_shift;
               carry_d = c_dig;
               cnt_d   = cnt_q + CW'(1);
               if (last_dig) begin
                  sum_d   = res_shift;
                  cout_d  = c_dig;
                  cmsb_d  = cin_msb;
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            if (abort_i || out_ready_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         cmsb_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         cmsb_q  <= cmsb_d;
      end
   end

   // Moore outputs decoded from state and registers.
   always_comb begin
      in_ready_o  = (state_q == StIdle);
      out_valid_o = (state_q == StDone);
      busy_o      = (state_q != StIdle);
      step_o      = (state_q == StShift);
      sum_o       = sum_q;
      carry_o     = cout_q;
      ovf_o       = cmsb_q ^ cout_q;
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: a bit-serial instance (DIGIT=1) and a nibble-serial
// instance (DIGIT=4) share operands; results are compared with an integer model.
module tb_serial_addsub;

   logic       clk = 1'b0;
   logic       resetn;
   logic [7:0] a, b;
   logic       sub, abort, out_ready, iv1, iv4;
   int         sel;
   int         total = 0;
   int         bad   = 0;

   logic       ir1, ov1, c1, o1, bz1, st1;
   logic       ir4, ov4, c4, o4, bz4, st4;
   logic [7:0] s1, s4;

   logic       ir, ov, co, of, bz, st;
   logic [7:0] so;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut1 (
      .clk_i(clk), .resetn_i(resetn), .in_valid_i(iv1), .in_ready_o(ir1),
      .a_i(a), .b_i(b), .sub_i(sub), .abort_i(abort), .out_valid_o(ov1),
      .out_ready_i(out_ready), .sum_o(s1), .carry_o(c1), .ovf_o(o1),
      .busy_o(bz1), .step_o(st1)
   );

   serial_addsub #(.WIDTH(8), .DIGIT(4)) u_dut4 (
      .clk_i(clk), .resetn_i(resetn), .in_valid_i(iv4), .in_ready_o(ir4),
      .a_i(a), .b_i(b), .sub_i(sub), .abort_i(abort), .out_valid_o(ov4),
      .out_ready_i(out_ready), .sum_o(s4), .carry_o(c4), .ovf_o(o4),
      .busy_o(bz4), .step_o(st4)
   );

   assign ir = (sel == 0) ? ir1 : ir4;
   assign ov = (sel == 0) ? ov1 : ov4;
   assign co = (sel == 0) ? c1  : c4;
   assign of = (sel == 0) ? o1  : o4;
   assign bz = (sel == 0) ? bz1 : bz4;
   assign st = (sel == 0) ? st1 : st4;
   assign so = (sel == 0) ? s1  : s4;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views of the operands.
   task automatic model(input logic [7:0] x, input logic [7:0] y, input logic s,
                        output logic [7:0] es, output logic ec, output logic eo);
      int ua, ub, r, sa, sb, sr;
      ua = int'(x);
      ub = int'(y);
      sa = (ua > 127) ? ua - 256 : ua;
      sb = (ub > 127) ? ub - 256 : ub;
      if (!s) begin
         r  = ua + ub;
         ec = (r > 255);
         sr = sa + sb;
      end else begin
         r  = ua - ub;
         ec = (ua >= ub);
         sr = sa - sb;
      end
      es = r[7:0];
      eo = (sr > 127) || (sr < -128);
   endtask

   // Full transaction; during a stall in DONE, junk requests are offered and must be ignored.
   task automatic run_op(input int dsel, input logic [7:0] x, input logic [7:0] y,
                         input logic s, input int stall, input string tag);
      logic [7:0] es;
      logic       ec, eo;
      int         n, lat, steps;
      n   = (dsel == 0) ? 8 : 2;
      sel = dsel;
      model(x, y, s, es, ec, eo);
      @(negedge clk);
      check({tag, "_ready"}, ir, 1'b1);
      a = x; b = y; sub = s;
      if (dsel == 0) iv1 = 1'b1; else iv4 = 1'b1;
      @(negedge clk);
      iv1 = 1'b0; iv4 = 1'b0;
      lat = 0; steps = 0;
      while (!ov && lat < 50) begin
         if (st) steps++;
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, lat, n);
      check({tag, "_steps"}, steps, n);
      check({tag, "_sum"}, so, es);
      check({tag, "_carry"}, co, ec);
      check({tag, "_ovf"}, of, eo);
      for (int i = 0; i < stall; i++) begin
         a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
         if (dsel == 0) iv1 = 1'b1; else iv4 = 1'b1;
         @(negedge clk);
         check({tag, "_hold_v"}, ov, 1'b1);
         check({tag, "_hold_s"}, {so, co, of}, {es, ec, eo});
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_idle"}, {ov, ir, bz}, 3'b010);
      iv1 = 1'b0; iv4 = 1'b0;
      check({tag, "_keep_s"}, {so, co, of}, {es, ec, eo});
   endtask

   initial begin
      logic       seen;
      int         lat;
      resetn = 1'b0; a = '0; b = '0; sub = 1'b0; abort = 1'b0;
      out_ready = 1'b0; iv1 = 1'b0; iv4 = 1'b0; sel = 0;
      #12;
      check("rst_out1", {s1, c1, o1, ov1, bz1, st1, ir1}, {8'h00, 6'b000001});
      check("rst_out4", {s4, c4, o4, ov4, bz4, st4, ir4}, {8'h00, 6'b000001});
      @(negedge clk);
      resetn = 1'b1;

      run_op(0, 8'h35, 8'h4A, 1'b0, 0, "add_7f");
      run_op(0, 8'h7F, 8'h01, 1'b0, 0, "add_ovf");
      run_op(0, 8'h10, 8'h20, 1'b1, 0, "sub_borrow");
      run_op(1, 8'hFF, 8'h01, 1'b0, 0, "d4_wrap");
      run_op(0, 8'h80, 8'h01, 1'b1, 5, "stall5");
      run_op(1, 8'h00, 8'h00, 1'b1, 2, "d4_sub0");

      // Abort at count 3, then confirm no result and a clean next operation.
      sel = 0;
      @(negedge clk);
      a = 8'hC3; b = 8'h5A; sub = 1'b0; iv1 = 1'b1;
      @(negedge clk);
      iv1 = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_in_shift", st, 1'b1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_idle", {bz, ir, st}, 3'b010);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ov) seen = 1'b1;
      end
      check("abort_no_valid", seen, 1'b0);
      run_op(0, 8'hC3, 8'h5A, 1'b1, 1, "after_abort");

      // Reset in the middle of SHIFT with a nonzero prior result on the outputs.
      run_op(0, 8'h7F, 8'h01, 1'b0, 0, "pre_reset");
      @(negedge clk);
      a = 8'h11; b = 8'h22; sub = 1'b0; iv1 = 1'b1;
      @(negedge clk);
      iv1 = 1'b0;
      @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      check("rst_mid", {s1, c1, o1, ov1, bz1, st1, ir1}, {8'h00, 6'b000001});
      @(negedge clk);
      resetn = 1'b1;
      a = 8'h01; b = 8'h02; sub = 1'b0; iv1 = 1'b1;
      @(negedge clk);
      iv1 = 1'b0;
      check("rst_first_accept", bz, 1'b1);
      lat = 0;
      while (!ov && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("rst_post_lat", lat, 8);
      check("rst_post_sum", so, 8'h03);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Random operations on both instances.
      for (int i = 0; i < 24; i++) begin
         run_op(i % 2, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
